// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared systolic-array constants for the input-skew and output-deskew blocks
package tpu_pkg;

   localparam int SA_DIM = 16;
   localparam int DATA_W = 32;

   // input skew delays lane i by i cycles, so its deepest lane holds SA_DIM-1 stages
   localparam int SKEW_MAX_DEPTH = SA_DIM - 1;
   localparam int SKEW_NUM_REGS  = SA_DIM * (SA_DIM - 1) / 2;

   // deskew is the mirror image: lane i waits out the remaining lanes-i cycles
   function automatic int deskew_depth(input int lane, input int lanes);
      return lanes - lane;
   endfunction

endpackage

// File: rtl/en_reg.sv
// rtl/en_reg.sv - data register with clock enable and asynchronous active-high clear
module en_reg #(
   parameter int W = tpu_pkg::DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/output_deskew.sv
// rtl/output_deskew.sv - re-aligns skewed systolic-array output lanes into whole vectors
module output_deskew #(
   parameter int N         = tpu_pkg::SA_DIM,
   parameter int DATA_W    = tpu_pkg::DATA_W,
   parameter int TILE_ROWS = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   in_valid,
   input  logic [N-1:0][DATA_W-1:0] data_in,
   output logic [N-1:0][DATA_W-1:0] data_out,
   output logic                   out_valid,
   output logic                   out_last,
   output logic                   busy
);

   localparam int RW = $clog2(TILE_ROWS) + 1;
   localparam int CW = $clog2(N + 1);

   // lane i arrives i cycles late, so it only needs N-i stages to line up with lane 0
   for (genvar i = 0; i < N; i++) begin : g_lane
      localparam int DEPTH = tpu_pkg::deskew_depth(i, N);
      logic [DATA_W-1:0] chain [DEPTH+1];

      assign chain[0] = data_in[i];
      for (genvar j = 0; j < DEPTH; j++) begin : g_stage
         en_reg #(.W(DATA_W)) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (chain[j]),
            .q   (chain[j+1])
         );
      end
      assign data_out[i] = chain[DEPTH];
   end

   logic [N-1:0]  vsr;
   logic [RW-1:0] row;
   logic [CW-1:0] inflight;
   logic          launch;
   logic          at_last;

   // shift form keeps the N=1 case legal
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         vsr <= '0;
      else if (en)
         vsr <= (vsr << 1) | N'(in_valid);
   end

   assign out_valid = vsr[N-1] & en;
   assign launch    = in_valid & en;
   assign at_last   = (row == RW'(TILE_ROWS - 1));
   assign out_last  = out_valid & at_last;
   assign busy      = (inflight != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         row <= '0;
      else if (out_valid)
         row <= at_last ? '0 : row + RW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         inflight <= '0;
      else begin
         case ({launch, out_valid})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_output_deskew.sv
// tb/tb_output_deskew.sv - directed self-checking bench for output_deskew
module tb_output_deskew;

   localparam int N = 4;
   localparam int W = tpu_pkg::DATA_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic in_valid = 1'b0;
   logic [N-1:0][W-1:0] data_in = '0;
   logic [N-1:0][W-1:0] data_out;
   logic out_valid, out_last, busy;

   logic en1 = 1'b0;
   logic in_valid1 = 1'b0;
   logic [0:0][W-1:0] data_in1 = '0;
   logic [0:0][W-1:0] data_out1;
   logic out_valid1, out_last1, busy1;

   int nvec = 0;
   int nerr = 0;
   int wf [0:127];
   int adv;
   int rows;

   bit          vseq [8] = '{1, 0, 1, 1, 0, 1, 0, 0};
   logic [31:0] dseq [8] = '{32'hA5A5_0001, 32'h0000_0002, 32'hFFFF_FFFF, 32'h1234_5678,
                             32'h0BAD_F00D, 32'h8000_0000, 32'h0000_0007, 32'h0000_0000};

   always #5 clk = ~clk;

   output_deskew #(.N(N), .DATA_W(W), .TILE_ROWS(4)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .data_in(data_in),
      .data_out(data_out), .out_valid(out_valid), .out_last(out_last), .busy(busy)
   );

   output_deskew #(.N(1), .DATA_W(W), .TILE_ROWS(1)) dut1 (
      .clk(clk), .rst(rst), .en(en1), .in_valid(in_valid1), .data_in(data_in1),
      .data_out(data_out1), .out_valid(out_valid1), .out_last(out_last1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit has_wf(input int l);
      if (l < 0 || l > 127) return 1'b0;
      return wf[l] >= 0;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 128; i++) wf[i] = -1;
      adv  = 0;
      rows = 0;
   endtask

   // lane i carries wavefront adv-i; idle lanes get junk that must never surface as a beat
   task automatic drive(input bit e);
      int l;
      en       = e;
      in_valid = has_wf(adv);
      for (int i = 0; i < N; i++) begin
         l = adv - i;
         if (has_wf(l)) data_in[i] = W'(wf[l] + i);
         else           data_in[i] = {16'hBAD0, 8'(adv), 8'(i)};
      end
   endtask

   task automatic step(input bit e);
      logic [N-1:0][W-1:0] exp_d;
      bit vh, ev;
      int cnt;
      drive(e);
      #1;
      vh  = has_wf(adv - N);
      ev  = e && vh;
      cnt = 0;
      for (int l = adv - N; l < adv; l++) if (has_wf(l)) cnt++;
      chk("out_valid", 128'(out_valid), 128'(ev));
      chk("out_last", 128'(out_last), 128'(ev && rows == 3));
      chk("busy", 128'(busy), 128'(cnt != 0));
      chk("inflight", 128'(dut.inflight), 128'(cnt));
      if (vh) begin
         for (int i = 0; i < N; i++) exp_d[i] = W'(wf[adv - N] + i);
         chk("data_out", 128'(data_out), 128'(exp_d));
      end
      if (ev) rows = (rows + 1) % 4;
      @(posedge clk);
      #1;
      if (e) adv++;
   endtask

   task automatic do_reset();
      clear_model();
      drive(1'b1);
      #2 rst = 1'b1;
      #1;
      chk("rst_data_out", 128'(data_out), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_last", 128'(out_last), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      @(posedge clk);
      #1;
      chk("rst_hold_data_out", 128'(data_out), 128'(0));
      chk("rst_hold_out_valid", 128'(out_valid), 128'(0));
      rst = 1'b0;
   endtask

   initial begin
      clear_model();
      #1;
      do_reset();

      // single wavefront, lane i = 0x10+i
      wf[0] = 32'h10;
      repeat (7) step(1'b1);

      // eight back-to-back wavefronts with a 3-cycle stall mid-stream
      do_reset();
      for (int k = 1; k <= 8; k++) wf[k-1] = 32'h100 * k;
      repeat (6) step(1'b1);
      repeat (3) step(1'b0);
      repeat (8) step(1'b1);

      // reset with two wavefronts in flight and row counter at 2
      do_reset();
      for (int k = 0; k < 4; k++) wf[k] = 32'h1000 + 32'h100 * k;
      repeat (6) step(1'b1);
      chk("pre_rst_busy", 128'(busy), 128'(1));
      do_reset();
      for (int k = 0; k < 5; k++) wf[k] = 32'h2000 + 32'h100 * k;
      repeat (11) step(1'b1);

      // long stream: in-flight count pinned at N
      do_reset();
      for (int k = 0; k < 24; k++) wf[k] = 32'h40000 + 32'h100 * k;
      repeat (30) step(1'b1);

      // single-lane instance: one-cycle delay of data and valid
      en1 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_valid1   = vseq[k];
         data_in1[0] = dseq[k];
         #1;
         if (k > 0) begin
            chk("n1_out_valid", 128'(out_valid1), 128'(vseq[k-1]));
            chk("n1_out_last", 128'(out_last1), 128'(vseq[k-1]));
            chk("n1_data_out", 128'(data_out1), 128'(dseq[k-1]));
         end
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
